// File: rtl/matmul4x4_sequencer_pkg.sv
// Shared types and constants for the 4x4 complex matrix-multiply sequencer.
// Includes the FSM state encoding, index width, and the result-tag record.
package matmul4x4_sequencer_pkg;

  localparam int IDX_W       = 2;
  localparam int MAC_LAT_MAX = 8;
  localparam int NUM_OUTPUTS = 16;
  localparam int NUM_ISSUES  = NUM_OUTPUTS * (1 << IDX_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/matmul4x4_sequencer_tag_delay.sv
// Fixed-depth shift register that carries result tags alongside the MAC pipeline.
// The tag emerges in step with the accumulated value it describes.
module matmul_tag_delay
  import matmul4x4_sequencer_pkg::*;
#(
  parameter int Depth = 3
) (
  input  logic CLK,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [Depth];

  // NOTE: every stage is cleared on reset so no stale write can leak out after an abort.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < Depth; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[Depth-1];

endmodule

// File: rtl/matmul4x4_sequencer.sv
// Control FSM for the 4x4 complex matrix multiplier.
// Loads the operands, walks (row, col, k) through one MAC, and tags finished elements.
module matmul4x4_sequencer
  import matmul4x4_sequencer_pkg::*;
#(
  parameter int MacLatency = 3,
  parameter int N          = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Start,
  input  logic             Stall,
  output logic             LoadEnable,
  output logic [IDX_W-1:0] Row,
  output logic [IDX_W-1:0] Col,
  output logic [IDX_W-1:0] K,
  output logic             MacValid,
  output logic             MacClear,
  output logic             ResultWrite,
  output logic [IDX_W-1:0] ResultRow,
  output logic [IDX_W-1:0] ResultCol,
  output logic             Busy,
  output logic             Done
);

  localparam int ISSUE_W = 3 * IDX_W;
  localparam int DRAIN_W = $clog2(MAC_LAT_MAX + 1);
  localparam logic [ISSUE_W-1:0] LAST_ISSUE = ISSUE_W'(NUM_ISSUES - 1);
  localparam logic [IDX_W-1:0]   LAST_K     = IDX_W'(N - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(MacLatency - 1);

  state_t             state;
  state_t             state_next;
  logic [ISSUE_W-1:0] issue_idx;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               issue_fire;
  tag_t               tag_in;
  tag_t               tag_out;

  // One flat counter: k occupies the low bits so it runs innermost, then col, then row.
  assign {Row, Col, K} = issue_idx;
  assign issue_fire    = (state == S_ISSUE) && !Stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_LOAD;
      S_LOAD:  state_next = S_ISSUE;
      S_ISSUE: if (issue_fire && (issue_idx == LAST_ISSUE)) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == LAST_DRAIN) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      issue_idx <= '0;
      drain_cnt <= '0;
    end else begin
      if (issue_fire) issue_idx <= issue_idx + ISSUE_W'(1);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  always_comb begin
    LoadEnable = 1'b0;
    MacValid   = 1'b0;
    MacClear   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_LOAD: begin
        LoadEnable = 1'b1;
        Busy       = 1'b1;
      end
      S_ISSUE: begin
        Busy     = 1'b1;
        MacValid = issue_fire;
        MacClear = issue_fire && (K == '0);
      end
      S_DRAIN: Busy = 1'b1;
      S_DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // Stalled cycles push bubbles, so writes stay aligned with the free-running MAC.
  assign tag_in = {issue_fire && (K == LAST_K), Row, Col};

  matmul_tag_delay #(.Depth(MacLatency)) u_tag_delay (
    .CLK     (CLK),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign ResultWrite = tag_out.valid;
  assign ResultRow   = tag_out.row;
  assign ResultCol   = tag_out.col;

endmodule

// File: tb/tb_matmul4x4_sequencer.sv
// Self-checking bench: three sequencers (MacLatency 1, 3, 8) share stimulus and are
// compared cycle by cycle against a timeline model built from the run rules.
module tb_matmul4x4_sequencer;

  localparam int NDUT = 3;
  localparam int MAXC = 256;

  typedef struct packed {
    logic       load;
    logic       busy;
    logic       done;
    logic       mv;
    logic       mc;
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] k;
    logic       rw;
    logic [1:0] rrow;
    logic [1:0] rcol;
  } obs_t;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0;
  logic Stall = 1'b0;

  logic [NDUT-1:0]      load_o, mv_o, mc_o, rw_o, busy_o, done_o;
  logic [NDUT-1:0][1:0] row_o, col_o, k_o, rrow_o, rcol_o;

  int   checks   = 0;
  int   failures = 0;
  bit   stall_pat [MAXC];
  bit   start_pat [MAXC];
  obs_t exp_tab   [NDUT][MAXC];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    matmul4x4_sequencer #(
      .MacLatency((g == 0) ? 1 : ((g == 1) ? 3 : 8)),
      .N(4)
    ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .Start       (Start),
      .Stall       (Stall),
      .LoadEnable  (load_o[g]),
      .Row         (row_o[g]),
      .Col         (col_o[g]),
      .K           (k_o[g]),
      .MacValid    (mv_o[g]),
      .MacClear    (mc_o[g]),
      .ResultWrite (rw_o[g]),
      .ResultRow   (rrow_o[g]),
      .ResultCol   (rcol_o[g]),
      .Busy        (busy_o[g]),
      .Done        (done_o[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic obs_t observe(input int g);
    obs_t o;
    o.load = load_o[g];
    o.busy = busy_o[g];
    o.done = done_o[g];
    o.mv   = mv_o[g];
    o.mc   = mc_o[g];
    o.row  = row_o[g];
    o.col  = col_o[g];
    o.k    = k_o[g];
    o.rw   = rw_o[g];
    o.rrow = rrow_o[g];
    o.rcol = rcol_o[g];
    return o;
  endfunction

  // Result coordinates only carry meaning on a write cycle.
  function automatic obs_t mask(input obs_t o, input bit keep);
    obs_t m = o;
    if (!keep) begin
      m.rrow = '0;
      m.rcol = '0;
    end
    return m;
  endfunction

  // Timeline model: a run started at t loads at t+1, issues on the unstalled cycles that
  // follow (64 of them), writes element (i,j) Latency cycles after its k=3 issue, drains
  // for Latency cycles, then pulses Done. Reset wipes everything after the reset cycle.
  task automatic build_model(input int rst_cyc, input int ncyc);
    int lat, t, c, n;
    for (int g = 0; g < NDUT; g++)
      for (int i = 0; i < MAXC; i++) exp_tab[g][i] = '0;
    for (int g = 0; g < NDUT; g++) begin
      lat = lat_of(g);
      t   = 0;
      while (t < ncyc) begin
        if (start_pat[t]) begin
          c = t + 1;
          exp_tab[g][c].load = 1'b1;
          exp_tab[g][c].busy = 1'b1;
          c++;
          n = 0;
          while (n < 64 && c < ncyc) begin
            exp_tab[g][c].busy = 1'b1;
            exp_tab[g][c].row  = 2'(n / 16);
            exp_tab[g][c].col  = 2'((n / 4) % 4);
            exp_tab[g][c].k    = 2'(n % 4);
            if (!stall_pat[c]) begin
              exp_tab[g][c].mv = 1'b1;
              exp_tab[g][c].mc = (n % 4 == 0);
              if (n % 4 == 3) begin
                exp_tab[g][c+lat].rw   = 1'b1;
                exp_tab[g][c+lat].rrow = 2'(n / 16);
                exp_tab[g][c+lat].rcol = 2'((n / 4) % 4);
              end
              n++;
            end
            c++;
          end
          if (n < 64) begin
            t = ncyc;
          end else begin
            for (int d = 0; d < lat; d++) exp_tab[g][c+d].busy = 1'b1;
            exp_tab[g][c+lat].busy = 1'b1;
            exp_tab[g][c+lat].done = 1'b1;
            t = c + lat + 1;
          end
        end else begin
          t++;
        end
      end
      if (rst_cyc >= 0)
        for (int i = rst_cyc + 1; i < MAXC; i++) exp_tab[g][i] = '0;
    end
  endtask

  // mode: 0 no stall, 1 stall on cycles 10..14, 2 stall on odd cycles, 3 random 25% stall.
  task automatic run_case(input string name, input int mode, input bit hold,
                          input int rst_cyc, input int ncyc);
    int   wr_dut [NDUT];
    int   wr_exp [NDUT];
    obs_t o, e;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        1:       stall_pat[c] = (c >= 10 && c <= 14);
        2:       stall_pat[c] = (c % 2 == 1);
        3:       stall_pat[c] = ($urandom_range(0, 3) == 0);
        default: stall_pat[c] = 1'b0;
      endcase
      if (rst_cyc >= 0 && c > rst_cyc) start_pat[c] = 1'b0;
      else                             start_pat[c] = hold ? 1'b1 : (c == 0);
    end
    build_model(rst_cyc, ncyc);
    for (int g = 0; g < NDUT; g++) begin
      wr_dut[g] = 0;
      wr_exp[g] = 0;
    end

    @(negedge CLK);
    reset = 1'b1;
    Start = 1'b0;
    Stall = 1'b0;
    @(negedge CLK);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge CLK);
      reset = (c == rst_cyc);
      Start = start_pat[c];
      Stall = stall_pat[c];
      #1;
      for (int g = 0; g < NDUT; g++) begin
        o = observe(g);
        e = exp_tab[g][c];
        check($sformatf("%s L%0d cyc%0d", name, lat_of(g), c), 32'(mask(o, e.rw)), 32'(mask(e, e.rw)));
        wr_dut[g] += int'(o.rw);
        wr_exp[g] += int'(e.rw);
      end
    end
    for (int g = 0; g < NDUT; g++)
      check($sformatf("%s L%0d write_count", name, lat_of(g)), 32'(wr_dut[g]), 32'(wr_exp[g]));
    reset = 1'b0;
    Start = 1'b0;
    Stall = 1'b0;
  endtask

  initial begin
    run_case("nominal",      0, 1'b0, -1,  90);
    run_case("stall10_14",   1, 1'b0, -1,  90);
    run_case("start_held",   0, 1'b1, -1, 160);
    run_case("reset_at_30",  0, 1'b0, 30,  90);
    run_case("stall_toggle", 2, 1'b0, -1, 150);
    run_case("stall_random", 3, 1'b0, -1, 200);
    run_case("random_held",  3, 1'b1, -1, 220);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
